pc_n2t: RTL and testbench

- Parametrised program counter; the next generation after the single-bit and fixed-width registers.
- Holds a WIDTH-bit value and supports synchronous reset, parallel load, increment and decrement, each by a configurable STEP.
- Emits a one-cycle wrap pulse when the count crosses its modular boundary.
- Feeds the instruction-address path of the CPU datapath and doubles as a general loop or address counter.

---
 rtl/pc_n2t.sv | 61 ++++++
 tb/tb_pc_n2t.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_n2t.sv
// pc_n2t: parametrised program counter with reset, load, +/-STEP and a wrap pulse.
`timescale 1ns/1ps
module pc_n2t #(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       STEP        = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  // One extra bit so the carry/borrow of the modular update is visible.
  localparam int unsigned     W1     = WIDTH + 1;
  localparam logic [W1-1:0]   STEP_X = W1'(STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [W1-1:0]    sum_c, diff_c;

  // Widened add/subtract; top bit is carry on inc, borrow on dec.
  always_comb begin
    sum_c  = {1'b0, out_q} + STEP_X;
    diff_c = {1'b0, out_q} - STEP_X;
  end

  // Next-state selection in priority order below reset; wrap defaults low.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = in;
    end else if (inc && !dec) begin
      out_d  = sum_c[WIDTH-1:0];
      wrap_d = sum_c[WIDTH];
    end else if (dec && !inc) begin
      out_d  = diff_c[WIDTH-1:0];
      wrap_d = diff_c[WIDTH];
    end
  end

  // State register; synchronous reset overrides every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_n2t.sv
// Bench for pc_n2t: directed plan plus random traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_pc_n2t;

  logic clk;

  // Instance A: defaults (16 bit, step 1, reset 0)
  logic        a_rst, a_ld, a_inc, a_dec, a_wrap;
  logic [15:0] a_in, a_out;
  // Instance B: 4 bit, step 3, reset 13
  logic        b_rst, b_ld, b_inc, b_dec, b_wrap;
  logic [3:0]  b_in, b_out;

  pc_n2t u_a (
    .clk(clk), .reset(a_rst), .in(a_in), .load(a_ld), .inc(a_inc), .dec(a_dec),
    .out(a_out), .wrap(a_wrap)
  );

  pc_n2t #(.WIDTH(4), .STEP(3), .RESET_VALUE(4'hD)) u_b (
    .clk(clk), .reset(b_rst), .in(b_in), .load(b_ld), .inc(b_inc), .dec(b_dec),
    .out(b_out), .wrap(b_wrap)
  );

  always #5 clk = ~clk;

  int vec;
  int errs;

  // Reference state
  longint a_exp, b_exp;
  bit     a_wexp, b_wexp;
  bit     a_valid, b_valid;

  // Behavioural next value from the priority rules, plain integer arithmetic.
  function automatic void ref_next(input int unsigned w, input longint step, input longint rv,
                                   input longint cur, input longint ldv,
                                   input bit r, input bit l, input bit i, input bit d,
                                   output longint nxt, output bit wr);
    longint m;
    m   = longint'(1) << w;
    wr  = 1'b0;
    nxt = cur;
    if (r)            nxt = rv;
    else if (l)       nxt = ldv;
    else if (i && !d) begin
      nxt = cur + step;
      if (nxt >= m) begin wr = 1'b1; nxt = nxt - m; end
    end else if (d && !i) begin
      if (cur < step) begin wr = 1'b1; nxt = cur - step + m; end
      else nxt = cur - step;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance both models from the applied inputs, then compare.
  task automatic tick();
    longint n;
    bit     w;
    @(posedge clk);
    #1;
    ref_next(16, 1, 0, a_exp, longint'(a_in), a_rst, a_ld, a_inc, a_dec, n, w);
    if (a_rst) a_valid = 1'b1;
    a_exp = n; a_wexp = w;
    ref_next(4, 3, 13, b_exp, longint'(b_in), b_rst, b_ld, b_inc, b_dec, n, w);
    if (b_rst) b_valid = 1'b1;
    b_exp = n; b_wexp = w;
    if (a_valid) begin
      chk("a_model_out", 32'(a_out), 32'(a_exp));
      chk("a_model_wrap", 32'(a_wrap), 32'(a_wexp));
    end
    if (b_valid) begin
      chk("b_model_out", 32'(b_out), 32'(b_exp));
      chk("b_model_wrap", 32'(b_wrap), 32'(b_wexp));
    end
  endtask

  task automatic set_a(input bit r, input bit l, input bit i, input bit d, input logic [15:0] v);
    a_rst = r; a_ld = l; a_inc = i; a_dec = d; a_in = v;
  endtask

  task automatic set_b(input bit r, input bit l, input bit i, input bit d, input logic [3:0] v);
    b_rst = r; b_ld = l; b_inc = i; b_dec = d; b_in = v;
  endtask

  initial begin
    clk = 1'b0;
    vec = 0; errs = 0;
    a_exp = 0; b_exp = 0; a_wexp = 0; b_wexp = 0;
    a_valid = 0; b_valid = 0;
    set_a(0, 0, 0, 0, '0);
    set_b(0, 0, 0, 0, '0);
    #2;

    // Reset wins over load/inc
    set_a(1, 1, 1, 0, 16'h1234);
    set_b(1, 0, 0, 0, 4'h0);
    tick();
    chk("a_reset_out", 32'(a_out), 32'h0);
    chk("a_reset_wrap", 32'(a_wrap), 32'h0);
    chk("b_reset_out", 32'(b_out), 32'd13);
    set_a(0, 0, 0, 0, 16'h1234);
    set_b(0, 0, 0, 0, 4'h0);
    for (int k = 0; k < 3; k++) tick();
    chk("a_idle_hold", 32'(a_out), 32'h0);

    // Increment across the top
    set_a(0, 1, 0, 0, 16'hFFFE); tick();
    set_a(0, 0, 1, 0, 16'h0);    tick();
    chk("a_inc_ffff", 32'(a_out), 32'hFFFF);
    chk("a_inc_ffff_wrap", 32'(a_wrap), 32'h0);
    tick();
    chk("a_inc_wrap_out", 32'(a_out), 32'h0);
    chk("a_inc_wrap", 32'(a_wrap), 32'h1);
    set_a(0, 0, 0, 0, 16'h0); tick();
    chk("a_wrap_clears", 32'(a_wrap), 32'h0);
    chk("a_wrap_clears_out", 32'(a_out), 32'h0);

    // Decrement across zero, then inc+dec holds
    set_a(0, 1, 0, 0, 16'h0001); tick();
    set_a(0, 0, 0, 1, 16'h0);    tick();
    chk("a_dec_zero", 32'(a_out), 32'h0);
    chk("a_dec_zero_wrap", 32'(a_wrap), 32'h0);
    tick();
    chk("a_dec_borrow_out", 32'(a_out), 32'hFFFF);
    chk("a_dec_borrow", 32'(a_wrap), 32'h1);
    set_a(0, 0, 1, 1, 16'h0); tick();
    chk("a_incdec_hold", 32'(a_out), 32'hFFFF);
    chk("a_incdec_wrap", 32'(a_wrap), 32'h0);

    // Input changes while clk low do not reach out
    @(negedge clk);
    set_a(0, 1, 0, 0, 16'h00AA);
    #1;
    chk("a_no_comb_path", 32'(a_out), 32'hFFFF);
    tick();
    chk("a_load_aa", 32'(a_out), 32'h00AA);
    set_a(0, 1, 1, 0, 16'h0005); tick();
    chk("a_load_over_inc", 32'(a_out), 32'h5);
    set_a(0, 0, 0, 0, 16'h0);

    // Step 3 in 4 bits from reset value 13
    set_b(0, 0, 1, 0, 4'h0); tick();
    chk("b_inc_wrap_out", 32'(b_out), 32'd0);
    chk("b_inc_wrap", 32'(b_wrap), 32'h1);
    tick();
    chk("b_inc3", 32'(b_out), 32'd3);
    chk("b_inc3_wrap", 32'(b_wrap), 32'h0);
    set_b(0, 0, 0, 1, 4'h0); tick();
    chk("b_dec0", 32'(b_out), 32'd0);
    chk("b_dec0_wrap", 32'(b_wrap), 32'h0);
    tick();
    chk("b_dec_borrow_out", 32'(b_out), 32'd13);
    chk("b_dec_borrow", 32'(b_wrap), 32'h1);
    set_b(0, 0, 0, 0, 4'h0);

    // Reset mid-count
    set_a(1, 0, 0, 0, 16'h0); tick();
    set_a(0, 0, 1, 0, 16'h0);
    for (int k = 0; k < 7; k++) tick();
    chk("a_count7", 32'(a_out), 32'h7);
    set_a(1, 0, 1, 0, 16'h0); tick();
    chk("a_midreset_out", 32'(a_out), 32'h0);
    chk("a_midreset_wrap", 32'(a_wrap), 32'h0);
    set_a(0, 0, 1, 0, 16'h0); tick();
    chk("a_resume", 32'(a_out), 32'h1);

    // Random traffic, loads biased toward the boundaries
    for (int k = 0; k < 600; k++) begin
      logic [15:0] av;
      logic [3:0]  bv;
      case ($urandom_range(0, 3))
        0:       av = 16'hFFFF - 16'($urandom_range(0, 2));
        1:       av = 16'($urandom_range(0, 2));
        default: av = 16'($urandom);
      endcase
      bv = 4'($urandom);
      set_a($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 1'($urandom), av);
      set_b($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 1'($urandom), bv);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
